instr_fetch: RTL and testbench

//  Upstream feeder of the frontend decode/rename stage. Loads the 6502 reset vector,

---
 rtl/instr_fetch_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/instr_fetch.sv | 110 +++++++++++
 tb/tb_instr_fetch.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared state encodings and FIFO entry layout for instr_fetch
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH_VEC_LO   = 2'd0,
    FETCH_VEC_HI   = 2'd1,
    FETCH_VEC_WAIT = 2'd2,
    FETCH_RUN      = 2'd3
  } fetch_state_e;

  localparam int FETCH_ENTRY_SZ = 24;

  // Data byte in the upper bits, source address below it.
  typedef struct packed {
    logic [7:0]  data;
    logic [15:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small synchronous FIFO with flush for fetched instruction bytes
module fetch_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (count_q != '0);

  // Storage, pointers and occupancy; flush wins over any push/pop that cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - reset-vector load and byte-stream instruction fetch into the frontend
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] VEC_ADDR = 16'hFFFC
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] addr_i,
  input  logic [7:0]  din_i,
  output logic [7:0]  instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_pc
);

  localparam int          CW          = $clog2(DEPTH) + 1;
  localparam logic [15:0] VEC_ADDR_HI = VEC_ADDR + 16'd1;

  fetch_state_e  state_q;
  logic [15:0]   fetch_pc_q;
  logic [15:0]   resp_pc_q;
  logic [15:0]   addr_q;
  logic          inflight_q;

  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic [CW:0]   occupancy;
  logic          issue;
  logic          pop;
  logic          push;
  logic [15:0]   fetch_pc_d;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

  // Conservative credit: a byte already in flight reserves a slot, pops give no credit.
  assign occupancy  = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
  assign issue      = (state_q == FETCH_RUN) && !redirect && (occupancy < (CW+1)'(DEPTH));
  assign fetch_pc_d = fetch_pc_q + 16'd1;

  assign push       = inflight_q && !redirect;
  assign push_entry = '{data: din_i, pc: resp_pc_q};

  assign instr_valid = !fifo_empty && !redirect;
  assign pop         = instr_valid && instr_ready;

  assign addr_i   = addr_q;
  assign instr    = head.data;
  assign instr_pc = head.pc;

  // Vector load, fetch sequencing and registered memory address; redirect overrides all.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FETCH_VEC_LO;
      fetch_pc_q <= '0;
      resp_pc_q  <= '0;
      inflight_q <= 1'b0;
      addr_q     <= VEC_ADDR;
    end else if (redirect) begin
      state_q    <= FETCH_RUN;
      fetch_pc_q <= redirect_pc;
      inflight_q <= 1'b0;
      addr_q     <= redirect_pc;
    end else begin
      case (state_q)
        FETCH_VEC_LO: begin
          state_q <= FETCH_VEC_HI;
          addr_q  <= VEC_ADDR_HI;
        end
        FETCH_VEC_HI: begin
          fetch_pc_q[7:0] <= din_i;
          state_q         <= FETCH_VEC_WAIT;
        end
        FETCH_VEC_WAIT: begin
          fetch_pc_q[15:8] <= din_i;
          state_q          <= FETCH_RUN;
          addr_q           <= {din_i, fetch_pc_q[7:0]};
        end
        FETCH_RUN: begin
          inflight_q <= issue;
          if (issue) begin
            resp_pc_q  <= fetch_pc_q;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= fetch_pc_d;
          end
        end
        default: state_q <= FETCH_VEC_LO;
      endcase
    end
  end

  fetch_fifo #(
    .WIDTH (FETCH_ENTRY_SZ),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic [15:0] addr;
  logic [7:0]  din;
  logic [7:0]  instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [15:0] redirect_pc;

  logic [7:0]  mem [0:65535];
  logic [23:0] exp_q [$];
  int          tests;
  int          fails;

  instr_fetch #(
    .DEPTH    (4),
    .VEC_ADDR (16'hFFFC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .addr_i      (addr),
    .din_i       (din),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read instruction memory
  always @(posedge clk) din <= mem[addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: every handshake transfer must match the head of the scoreboard queue
  always @(negedge clk) begin
    if (rst === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_out: got pc=%h data=%h, required no transfer", instr_pc, instr);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        if ({instr, instr_pc} !== e) begin
          fails++;
          $display("FAIL stream: got pc=%h data=%h, required pc=%h data=%h",
                   instr_pc, instr, e[15:0], e[23:16]);
        end
      end
    end
  end

  task automatic push_exp(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      logic [15:0] a;
      a = base + 16'(i);
      exp_q.push_back({mem[a], a});
    end
  endtask

  // Wait (bounded) until every expected byte was delivered, then stop accepting
  task automatic drain(input string name);
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 60) begin
      @(posedge clk);
      #1;
      b++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: got %0d bytes outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    instr_ready = 1'b0;
  endtask

  // Assert reset between edges, check async outputs, release just after a posedge
  task automatic do_reset(input string name);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check({name, "_rst_valid"}, 32'(instr_valid), 32'd0);
    check({name, "_rst_addr"},  32'(addr),        32'hFFFC);
    check({name, "_rst_instr"}, 32'(instr),       32'h00);
    check({name, "_rst_pc"},    32'(instr_pc),    32'h0000);
    exp_q.delete();
    instr_ready = 1'b0;
    redirect    = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Walk periods n=0..5 after reset release and check the vector boot timeline
  task automatic boot_check(input string name);
    @(negedge clk);
    check({name, "_n0_addr"}, 32'(addr), 32'hFFFC);
    @(negedge clk);
    check({name, "_n1_addr"}, 32'(addr), 32'hFFFD);
    @(negedge clk);
    @(negedge clk);
    check({name, "_n3_addr"},  32'(addr),        32'h8000);
    check({name, "_n3_valid"}, 32'(instr_valid), 32'd0);
    @(negedge clk);
    check({name, "_n4_valid"}, 32'(instr_valid), 32'd0);
    @(negedge clk);
    check({name, "_n5_valid"}, 32'(instr_valid), 32'd1);
    check({name, "_n5_pc"},    32'(instr_pc),    32'h8000);
    check({name, "_n5_instr"}, 32'(instr),       32'hA9);
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    rst         = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    for (int a = 0; a < 65536; a++) begin
      mem[a] = 8'(a) ^ 8'(a >> 8) ^ 8'h3C;
    end
    mem[16'hFFFC] = 8'h00;
    mem[16'hFFFD] = 8'h80;
    mem[16'h8000] = 8'hA9;
    mem[16'h8001] = 8'h01;
    mem[16'h8002] = 8'h85;
    mem[16'h8003] = 8'h10;

    // 1: vector load then stream with ready=1
    do_reset("t1");
    instr_ready = 1'b1;
    push_exp(16'h8000, 4);
    boot_check("t1");
    drain("t1");

    // FIFO fills behind ready=0: head 8004, fetch stalls at 8008
    repeat (8) @(negedge clk);
    check("full_valid", 32'(instr_valid), 32'd1);
    check("full_pc",    32'(instr_pc),    32'h8004);
    check("full_addr",  32'(addr),        32'h8008);

    // 5: async reset with a full FIFO, then the boot sequence repeats exactly
    do_reset("t5");
    instr_ready = 1'b1;
    push_exp(16'h8000, 4);
    boot_check("t5");
    drain("t5");

    // 2: backpressure from first valid for 10 cycles
    do_reset("t2");
    boot_check("t2");
    repeat (10) @(negedge clk);
    check("t2_hold_pc",    32'(instr_pc),    32'h8000);
    check("t2_hold_valid", 32'(instr_valid), 32'd1);
    check("t2_stall_addr", 32'(addr),        32'h8004);
    push_exp(16'h8000, 8);
    @(posedge clk);
    #1;
    instr_ready = 1'b1;
    drain("t2");

    // 3: redirect with FIFO non-empty and a byte in flight
    redirect    = 1'b1;
    redirect_pc = 16'h1234;
    @(negedge clk);
    check("t3_R_valid", 32'(instr_valid), 32'd0);
    @(posedge clk);
    #1;
    redirect    = 1'b0;
    instr_ready = 1'b1;
    push_exp(16'h1234, 4);
    @(negedge clk);
    check("t3_R1_valid", 32'(instr_valid), 32'd0);
    check("t3_R1_addr",  32'(addr),        32'h1234);
    @(negedge clk);
    check("t3_R2_valid", 32'(instr_valid), 32'd0);
    @(negedge clk);
    check("t3_R3_valid", 32'(instr_valid), 32'd1);
    check("t3_R3_pc",    32'(instr_pc),    32'h1234);
    drain("t3");

    // 4: address wrap FFFF -> 0000
    redirect    = 1'b1;
    redirect_pc = 16'hFFFE;
    push_exp(16'hFFFE, 4);
    @(posedge clk);
    #1;
    redirect    = 1'b0;
    instr_ready = 1'b1;
    drain("t4");

    // 6: redirect during VEC_HI abandons the vector load
    do_reset("t6");
    @(posedge clk);
    #1;
    redirect    = 1'b1;
    redirect_pc = 16'h4000;
    @(posedge clk);
    #1;
    redirect = 1'b0;
    @(negedge clk);
    check("t6_n2_addr", 32'(addr), 32'h4000);
    push_exp(16'h4000, 4);
    instr_ready = 1'b1;
    drain("t6");

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
